// File: rtl/vend_pkg.sv
// vend_pkg: shared vending coin values, payout FSM state encoding and product price
package vend_pkg;
  localparam int NICKEL_V = 1;
  localparam int DIME_V = 2;
  localparam int QUARTER_V = 5;
  localparam int PRICE_N = 7;
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_e;
endpackage

// File: rtl/coin_change_dispenser_if.sv
// coin_change_dispenser_if: vend-controller/hopper bundle for the payout block; COIN_INVENTORY_EN adds empty flags and short
interface coin_change_dispenser_if #(parameter int AMT_W = 5);
  logic start;
  logic [AMT_W-1:0] amount;
  logic hopper_ack;
  logic q_out, d_out, n_out, busy, done;
`ifdef COIN_INVENTORY_EN
  logic q_empty, d_empty, n_empty, short;
`endif
  modport master (
    output start, amount, hopper_ack,
`ifdef COIN_INVENTORY_EN
    output q_empty, d_empty, n_empty,
    input short,
`endif
    input q_out, d_out, n_out, busy, done
  );
  modport slave (
    input start, amount, hopper_ack,
`ifdef COIN_INVENTORY_EN
    input q_empty, d_empty, n_empty,
    output short,
`endif
    output q_out, d_out, n_out, busy, done
  );
endinterface

// File: rtl/coin_change_dispenser_coin_select.sv
// coin_select: largest eligible coin (quarter/dime/nickel) for a nickel-unit remainder; COIN_INVENTORY_EN skips empty hoppers
module coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 5
) (
  input logic [AMT_W-1:0] rem,
`ifdef COIN_INVENTORY_EN
  input logic q_empty,
  input logic d_empty,
  input logic n_empty,
`endif
  output logic [2:0] sel,
  output logic [AMT_W-1:0] val
);
  logic q_ok, d_ok, n_ok;
`ifdef COIN_INVENTORY_EN
  assign q_ok = !q_empty && rem >= AMT_W'(QUARTER_V);
  assign d_ok = !d_empty && rem >= AMT_W'(DIME_V);
  assign n_ok = !n_empty && rem >= AMT_W'(NICKEL_V);
`else
  assign q_ok = rem >= AMT_W'(QUARTER_V);
  assign d_ok = rem >= AMT_W'(DIME_V);
  assign n_ok = rem >= AMT_W'(NICKEL_V);
`endif
  assign sel = q_ok ? 3'b100 : d_ok ? 3'b010 : n_ok ? 3'b001 : 3'b000;
  assign val = q_ok ? AMT_W'(QUARTER_V) : d_ok ? AMT_W'(DIME_V) : n_ok ? AMT_W'(NICKEL_V) : '0;
endmodule

// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: greedy coin payout over a req/ack hopper with settle gap; COIN_INVENTORY_EN adds empty skipping and short
module coin_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W = 5,
  parameter int GAP_CYC = 2
) (
  input logic clk,
  input logic reset,
  coin_change_dispenser_if.slave bus
);
  state_e state, state_nxt;
  logic [AMT_W-1:0] rem, rem_nxt, cval, cval_nxt, val;
  logic [3:0] gap, gap_nxt;
  logic [2:0] coin, coin_nxt, sel;
  logic busy, busy_nxt, done, done_nxt, fin, acked;
  coin_select #(.AMT_W(AMT_W)) u_sel (
    .rem(rem),
`ifdef COIN_INVENTORY_EN
    .q_empty(bus.q_empty),
    .d_empty(bus.d_empty),
    .n_empty(bus.n_empty),
`endif
    .sel(sel),
    .val(val)
  );
  assign fin = state == SELECT && sel == 3'b000;
  assign acked = state == PULSE && bus.hopper_ack;
`ifdef COIN_INVENTORY_EN
  logic short_r;
  assign bus.short = short_r;
  always_ff @(posedge clk)
    short_r <= reset ? 1'b0 : fin && rem != '0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      cval <= '0;
      gap <= '0;
      coin <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      rem <= rem_nxt;
      cval <= cval_nxt;
      gap <= gap_nxt;
      coin <= coin_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  always_comb
    state_nxt = state == IDLE ? (bus.start ? SELECT : IDLE)
      : state == SELECT ? (fin ? DONE : PULSE)
      : state == PULSE ? (bus.hopper_ack ? GAP : PULSE)
      : state == GAP ? (gap <= 4'd1 ? SELECT : GAP)
      : IDLE;
  always_comb begin
    rem_nxt = state == IDLE && bus.start ? bus.amount : acked ? rem - cval : fin ? '0 : rem;
    cval_nxt = state == SELECT ? val : cval;
    gap_nxt = acked ? 4'(GAP_CYC) : state == GAP ? gap - 4'd1 : gap;
    coin_nxt = state == SELECT ? sel : state == PULSE && !bus.hopper_ack ? coin : 3'b000;
    busy_nxt = state == IDLE ? bus.start : state != DONE;
    done_nxt = fin;
  end
  assign bus.q_out = coin[2];
  assign bus.d_out = coin[1];
  assign bus.n_out = coin[0];
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb_coin_change_dispenser: randomized scoreboard bench against a greedy change reference model
module tb_coin_change_dispenser;
  localparam int GAP_CYC = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int ack_min = 0, ack_max = 0, dly = 0;
  bit ack_noise = 0, force_ack = 0;
  logic [2:0] prev = 3'b000, cur;
  int lowcnt = 0;
  bit had = 0;
  int ev;
  coin_change_dispenser_if #(.AMT_W(5)) bus();
  coin_change_dispenser #(.AMT_W(5), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input string name, input int act);
    if (exp_q.size() == 0) chk({name, "_unexpected"}, act, 99);
    else chk(name, act, exp_q.pop_front());
  endtask

  // Greedy change with optional empty hoppers; -1 marks a short payout.
  function automatic void model(input int a, input bit qe, input bit de, input bit ne);
    int r = a;
    forever begin
      if (!qe && r >= 5) begin exp_q.push_back(5); r -= 5; end
      else if (!de && r >= 2) begin exp_q.push_back(2); r -= 2; end
      else if (!ne && r >= 1) begin exp_q.push_back(1); r -= 1; end
      else break;
    end
    exp_q.push_back(r > 0 ? -1 : 0);
  endfunction

  initial begin
    bus.hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (force_ack) bus.hopper_ack = 1'b1;
      else if (bus.q_out | bus.d_out | bus.n_out) begin
        bus.hopper_ack = dly == 0;
        if (dly > 0) dly--;
      end else begin
        bus.hopper_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        dly = $urandom_range(ack_min, ack_max);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cur = {bus.q_out, bus.d_out, bus.n_out};
      if (!reset) begin
        chk("onehot", int'($countones(cur) <= 1), 1);
        if (cur != 3'b000 && prev == 3'b000) begin
          ev = cur[2] ? 5 : cur[1] ? 2 : 1;
          pop_cmp("coin", ev);
          if (had) chk("gap_len", lowcnt, GAP_CYC + 1);
        end
        if (bus.done) begin
`ifdef COIN_INVENTORY_EN
          ev = bus.short ? -1 : 0;
`else
          ev = 0;
`endif
          pop_cmp("done", ev);
          if (had) chk("tail_gap", lowcnt, GAP_CYC + 1);
          had = 0;
        end
      end
      if (cur != 3'b000) begin lowcnt = 0; had = 1; end
      else lowcnt++;
      if (!bus.busy) had = 0;
      prev = cur;
    end
  end

  task automatic set_empty(input bit qe, input bit de, input bit ne);
`ifdef COIN_INVENTORY_EN
    bus.q_empty = qe;
    bus.d_empty = de;
    bus.n_empty = ne;
`endif
  endtask

  task automatic txn(input int a, input bit ns, input bit qe, input bit de, input bit ne, input int exp_cyc);
    int cyc, bcnt;
    set_empty(qe, de, ne);
    model(a, qe, de, ne);
    bus.start = 1'b1;
    bus.amount = 5'(a);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!bus.done && cyc < 3000) begin
      if (bus.busy) bcnt++;
      if (ns) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.amount = 5'($urandom_range(1, 31));
      end
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) bcnt++;
    chk("done_seen", int'(bus.done), 1);
    chk("busy_len", bcnt, cyc);
    if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
    bus.start = ns;
    @(negedge clk);
    chk("idle_after", int'(bus.busy), 0);
    bus.start = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.amount = '0;
    set_empty(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_q", int'(bus.q_out), 0);
    chk("rst_d", int'(bus.d_out), 0);
    chk("rst_n", int'(bus.n_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b0;
    @(negedge clk);
    txn(8, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 2);
    ack_min = 5; ack_max = 5;
    txn(6, 0, 0, 0, 0, 0);
    ack_min = 0; ack_max = 2;
    txn(10, 1, 0, 0, 0, 0);
    ack_min = 40; ack_max = 40;
    exp_q.push_back(2);
    bus.start = 1'b1;
    bus.amount = 5'd2;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.d_out && cyc < 20) begin @(negedge clk); cyc++; end
    chk("d_out_seen", int'(bus.d_out), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_d", int'(bus.d_out), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    reset = 1'b0;
    force_ack = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_ack_busy", int'(bus.busy), 0);
    end
    force_ack = 0;
    chk("rst_sb_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    ack_min = 0; ack_max = 1;
`ifdef COIN_INVENTORY_EN
    txn(5, 0, 1, 0, 0, 0);
    txn(3, 0, 1, 1, 1, 2);
`endif
    ack_min = 0; ack_max = 3;
    ack_noise = 1;
    for (int i = 0; i < 40; i++) begin
`ifdef COIN_INVENTORY_EN
      txn($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
`else
      txn($urandom_range(0, 31), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
`endif
    end
    ack_noise = 0;
    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
Output-side counterpart of the coin-acceptor FSM: the acceptor takes nickel/dime/quarter coins in, and this block pays coins out.
- Given a change amount in nickel units, it drives the coin hopper one coin at a time using a greedy quarter/dime/nickel order.
- Each coin uses a req/ack handshake, followed by a settle gap.
- Sits between the vend controller, which supplies the amount and start, and the physical hopper driver.

Parameters:
AMT_W, 5, width of the amount input and the remaining register, in nickel units (max 31 = $1.55)
GAP_CYC, 2, idle cycles after each coin ack before the next coin is selected (hopper settle time); legal range 1..15

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
start  input  1  request a payout; accepted only in IDLE
amount  input  AMT_W  change to pay, in nickels; sampled on the accepting edge
hopper_ack  input  1  hopper has ejected the requested coin
q_out  output  1  quarter eject request (level, held until ack)
d_out  output  1  dime eject request
n_out  output  1  nickel eject request
busy  output  1  payout in progress
done  output  1  one-cycle pulse when payout is finished

Behaviour:
Reset:
- Registers clear on any clk edge with reset=1, overriding everything including mid-payout.
- After reset: state=IDLE, remaining=0, gap counter=0, q_out=d_out=n_out=busy=done=0.
- Any coin in flight is abandoned; a hopper_ack arriving after reset is ignored.

Outputs: all outputs are registered; at most one of q_out/d_out/n_out is high in any cycle.

States, with transitions taken at posedge clk:
- IDLE: if start=1, capture remaining<=amount, set busy=1, go to SELECT. start=0 holds.
- SELECT:
  - remaining=0: go to DONE.
  - remaining>=5: assert q_out, go to PULSE.
  - remaining>=2: assert d_out, go to PULSE.
  - otherwise: assert n_out, go to PULSE.
- PULSE:
  - Hold the selected coin output until hopper_ack=1 is sampled.
  - On that edge: remaining <= remaining - coin value (5, 2 or 1), drop the coin output, load the gap counter with GAP_CYC, go to GAP.
  - No timeout.
- GAP: count down; on the edge where the counter reaches 0, go to SELECT.
- DONE: done=1 for exactly one cycle; busy=0 and return to IDLE on the next edge.

Timing and handshake rules:
- busy is high from the cycle after acceptance through the DONE cycle inclusive.
- Latency: amount=0 gives done in the 2nd cycle after the accepting edge.
- start while not IDLE is ignored; no queueing.
- start in the same cycle DONE is exiting is not accepted; the caller re-asserts it.
- hopper_ack outside PULSE is ignored.
- A hopper_ack held high across the gap does not count twice: it is only sampled in PULSE.
- Subtraction never underflows, since greedy selection guarantees value<=remaining.

Optional Feature:
Macro: COIN_INVENTORY_EN.

Defined:
- Adds inputs q_empty, d_empty, n_empty (1 bit each) and output short (1 bit).
- SELECT skips any denomination whose empty flag is high and picks the largest coin with value<=remaining that is not empty.
- If remaining>0 and no coin qualifies: short=1 and done=1 together in the DONE cycle, then return to IDLE with remaining cleared.
- short resets to 0.

Undefined:
- The extra ports are absent.
- Selection is pure greedy.

Decomposition:
Shared package vend_pkg holds:
- nickel-unit coin constants: NICKEL_V=1, DIME_V=2, QUARTER_V=5;
- the state encoding typedef (IDLE, SELECT, PULSE, GAP, DONE);
- PRICE_N=7, the 35-cent price also used by the acceptor.

One natural sub-module, coin_select: combinational remaining (plus empty flags) -> one-hot coin choice and value. It is reused if the acceptor is ever reworked to nickel-unit arithmetic. Everything else, including the gap counter, stays in the top.

Test Plan:
- reset, start=1 with amount=8, ack 1 cycle after each request -> q_out, d_out, n_out in that order, each followed by a 2-cycle gap; done pulses once; busy falls with done.
- amount=0 -> no coin output; done=1 in the 2nd cycle after acceptance; busy high for exactly 2 cycles.
- amount=6, hopper_ack delayed 5 cycles per coin -> q_out held 5+ cycles then n_out; remaining decrements only on ack edges; done after the 2nd coin.
- start re-pulsed with amount=3 during a payout of amount=10 -> exactly 2 quarters; second request ignored; no extra coins.
- reset asserted while d_out=1 -> next cycle all outputs 0, state IDLE; a later stray hopper_ack is ignored.
- COIN_INVENTORY_EN with q_empty=1, amount=5 -> d_out, d_out, n_out, done; with all empty and amount=3 -> no coins, done=1 and short=1 together.
